gray_seq_ctrl: RTL and testbench
================================

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the counter and step-length width in bits.
REQ-002 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a run of len steps; sampled in IDLE only.
REQ-005 Port dir, input, 1 bit: run direction (0 = up, 1 = down); latched with start.
REQ-006 Port len, input, WIDTH bits: number of count steps in the run; latched with start.
REQ-007 Port abort, input, 1 bit: terminate the current run early.
REQ-008 Port clr, input, 1 bit: zero the counter; honoured in IDLE only.
REQ-009 Port gray_count, output, WIDTH bits: registered Gray-coded count.
REQ-010 Port busy, output, 1 bit: high while in RUN.
REQ-011 Port done, output, 1 bit: one-cycle pulse on normal run completion.
REQ-012 Port wrap, output, 1 bit: one-cycle pulse after a step that wraps the count.

Function
REQ-013 The block SHALL hold an internal WIDTH-bit binary count bin and drive gray_count = bin XOR (bin >> 1), registered.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 with abort=0 and len!=0 SHALL latch len into rem and dir into rdir, then enter RUN at that edge.
REQ-016 In IDLE, start=1 with abort=0 and len==0 SHALL enter DONE directly with no count change.
REQ-017 In IDLE, abort=1 SHALL take priority over start; the FSM stays in IDLE.
REQ-018 In IDLE with start=0 and clr=1, the block SHALL set bin to 0 at that edge; clr SHALL be ignored outside IDLE.
REQ-019 In IDLE with start=1 and clr=1, start SHALL win; the count is not cleared.
REQ-020 In RUN with abort=0, each edge SHALL step bin: +1 mod 2^WIDTH when rdir=0, -1 mod 2^WIDTH when rdir=1.
REQ-021 Each RUN step SHALL decrement rem; the step taken with rem==1 SHALL also move the FSM to DONE.
REQ-022 In RUN, abort=1 SHALL return the FSM to IDLE at that edge with no step taken, bin held, and no done pulse.
REQ-023 start, dir and len SHALL be ignored while in RUN or DONE.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-025 wrap SHALL be registered high for the one cycle following a step from all-ones to 0 (up) or from 0 to all-ones (down).
REQ-026 busy SHALL equal (state==RUN).
REQ-027 Timing: if start is sampled at edge E0, steps occur at edges E1..Elen and done is high in the cycle after Elen.
REQ-028 The count SHALL persist across runs; the next run continues from the current value.
REQ-029 The maximum run length SHALL be 2^WIDTH-1 steps.

Reset
REQ-030 At any edge with reset=1, the block SHALL set state=IDLE, bin=0, rem=0, rdir=0, gray_count=0, busy=0, done=0 and wrap=0.
REQ-031 Reset SHALL override all other inputs, including mid-RUN and in DONE; no done pulse is issued for the interrupted run.

Verification
REQ-032 Hold reset 10 cycles, then release -> gray_count=0000, busy=0, done=0, wrap=0.
REQ-033 From bin=0, start, dir=0, len=5 -> gray_count 0001, 0011, 0010, 0110, 0111 on consecutive cycles; busy high 5 cycles; done pulses once; wrap stays 0.
REQ-034 From bin=0, start, dir=1, len=2 -> gray_count 1000 then 1001; wrap pulses once, after the first step; done pulses once.
REQ-035 Start, dir=0, len=15 from bin=0, then abort after 3 steps -> gray_count holds 0010; busy drops; no done; a following clr gives 0000.
REQ-036 Start with len=0 -> done pulses the next cycle; busy stays 0; gray_count unchanged.
REQ-037 Reset asserted mid-run -> all outputs 0 at the next edge; no done; a new start behaves as in REQ-033.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: run-length controlled up/down counter presented as a registered Gray code
module gray_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] len,
  input  logic             abort,
  input  logic             clr,
  output logic [WIDTH-1:0] gray_count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] bin, bin_n, rem, rem_n;
  logic rdir, rdir_n, step;
  always_comb begin
    state_n = state;
    bin_n = bin;
    rem_n = rem;
    rdir_n = rdir;
    step = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = (len == '0) ? DONE : RUN;
          rem_n = len;
          rdir_n = dir;
        end else if (!start && clr) begin
          bin_n = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          step = 1'b1;
          bin_n = rdir ? bin - WIDTH'(1) : bin + WIDTH'(1);
          rem_n = rem - WIDTH'(1);
          state_n = (rem == WIDTH'(1)) ? DONE : RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // gray_count is registered from bin_n so it always matches the bin register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bin <= '0;
      rem <= '0;
      rdir <= 1'b0;
      gray_count <= '0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      bin <= bin_n;
      rem <= rem_n;
      rdir <= rdir_n;
      gray_count <= bin_n ^ (bin_n >> 1);
      wrap <= step && (rdir ? (bin == '0) : (&bin));
    end
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: scoreboard bench for gray_seq_ctrl with WIDTH=4
module tb_gray_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, dir = 1'b0, abort = 1'b0, clr = 1'b0;
  logic [3:0] len = '0;
  logic [3:0] gray_count;
  logic busy, done, wrap;
  int n_checks = 0;
  int n_fails = 0;
  typedef struct packed {
    logic [3:0] g;
    logic b;
    logic d;
    logic w;
  } exp_t;
  exp_t sb[$];
  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .len(len),
    .abort(abort), .clr(clr), .gray_count(gray_count), .busy(busy),
    .done(done), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic st, input logic d, input logic [3:0] l, input logic ab,
                     input logic cl, input logic rs, input logic [3:0] eg, input logic eb,
                     input logic ed, input logic ew, input string tag);
    exp_t e;
    start = st;
    dir = d;
    len = l;
    abort = ab;
    clr = cl;
    reset = rs;
    sb.push_back('{g: eg, b: eb, d: ed, w: ew});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".gray"}, 32'(gray_count), 32'(e.g));
    check({tag, ".busy"}, 32'(busy), 32'(e.b));
    check({tag, ".done"}, 32'(done), 32'(e.d));
    check({tag, ".wrap"}, 32'(wrap), 32'(e.w));
  endtask
  task automatic idle(input logic [3:0] eg, input string tag);
    cyc(0, 0, 0, 0, 0, 0, eg, 0, 0, 0, tag);
  endtask
  task automatic run5(input string tag);
    cyc(1, 0, 5, 0, 0, 0, 4'b0000, 1, 0, 0, {tag, ".e0"});
    cyc(0, 0, 0, 0, 0, 0, 4'b0001, 1, 0, 0, {tag, ".e1"});
    cyc(0, 0, 0, 0, 0, 0, 4'b0011, 1, 0, 0, {tag, ".e2"});
    cyc(0, 0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, {tag, ".e3"});
    cyc(0, 0, 0, 0, 0, 0, 4'b0110, 1, 0, 0, {tag, ".e4"});
    cyc(0, 0, 0, 0, 0, 0, 4'b0111, 0, 1, 0, {tag, ".e5"});
  endtask
  initial begin
    logic [3:0] b;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, "reset_hold");
    idle(4'b0000, "reset_release");
    run5("up5");
    idle(4'b0111, "up5_after");
    cyc(0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, "clr1");
    cyc(1, 1, 2, 0, 0, 0, 4'b0000, 1, 0, 0, "dn2.e0");
    cyc(1, 0, 7, 0, 0, 0, 4'b1000, 1, 0, 1, "dn2.e1");
    cyc(0, 0, 0, 0, 0, 0, 4'b1001, 0, 1, 0, "dn2.e2");
    idle(4'b1001, "dn2_after");
    cyc(0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, "clr2");
    cyc(1, 0, 15, 0, 0, 0, 4'b0000, 1, 0, 0, "abort.e0");
    cyc(0, 0, 0, 0, 0, 0, 4'b0001, 1, 0, 0, "abort.e1");
    cyc(0, 0, 0, 0, 1, 0, 4'b0011, 1, 0, 0, "abort.clr_in_run");
    cyc(0, 0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, "abort.e3");
    cyc(0, 0, 0, 1, 0, 0, 4'b0010, 0, 0, 0, "abort.hit");
    idle(4'b0010, "abort_after");
    cyc(0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, "abort_clr");
    cyc(1, 0, 3, 1, 0, 0, 4'b0000, 0, 0, 0, "idle_abort_prio");
    idle(4'b0000, "idle_abort_after");
    cyc(1, 0, 1, 0, 1, 0, 4'b0000, 1, 0, 0, "start_beats_clr");
    cyc(0, 0, 0, 0, 0, 0, 4'b0001, 0, 1, 0, "len1.e1");
    idle(4'b0001, "len1_after");
    cyc(1, 0, 0, 0, 0, 0, 4'b0001, 0, 1, 0, "len0");
    idle(4'b0001, "len0_after");
    cyc(1, 0, 15, 0, 0, 0, 4'b0001, 1, 0, 0, "max.e0");
    for (int i = 1; i <= 15; i++) begin
      b = 4'(1 + i);
      cyc(0, 0, 0, 0, 0, 0, b ^ (b >> 1), i < 15, i == 15, i == 15, $sformatf("max.e%0d", i));
    end
    idle(4'b0000, "max_after");
    cyc(1, 0, 5, 0, 0, 0, 4'b0000, 1, 0, 0, "rst_mid.e0");
    cyc(0, 0, 0, 0, 0, 0, 4'b0001, 1, 0, 0, "rst_mid.e1");
    cyc(0, 0, 0, 0, 0, 0, 4'b0011, 1, 0, 0, "rst_mid.e2");
    cyc(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, "rst_mid.reset");
    idle(4'b0000, "rst_mid.release");
    run5("rerun");
    idle(4'b0111, "rerun_after");
    cyc(0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, "clr3");
    cyc(1, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, "rst_done.enter");
    idle(4'b0000, "rst_done.leave");
    cyc(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0, "rst_in_done.e0");
    cyc(0, 0, 0, 0, 0, 0, 4'b1000, 0, 1, 1, "rst_in_done.e1");
    cyc(0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, "rst_in_done.reset");
    idle(4'b0000, "final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
